pipe_skid_reg: RTL

- Parametrised pipeline-stage register that replaces the fixed-field, stall-coded inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Payload is an opaque DATA_W bus; stage flow uses a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready, so no combinational ready path crosses stages.
- Adds flush (kill in-flight entries) and a saturating back-pressure counter for performance debug.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_sat_counter.sv | 37 +++
 rtl/pipe_skid_reg.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage register types and payload widths
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

  // All-zero payload decodes as a NOP: no register write, no memory access.
  localparam logic [127:0] NOP_PAYLOAD = '0;

  localparam int REG_BUS_W    = 32;
  localparam int ALU_OP_BUS_W = 8;
  localparam int ALU_SEL_W    = 3;
  localparam int REG_ADDR_W   = 5;
  localparam int INST_ADDR_W  = 32;

  localparam int IF_ID_W  = INST_ADDR_W + REG_BUS_W;
  localparam int ID_EX_W  = ALU_OP_BUS_W + ALU_SEL_W + 2 * REG_BUS_W + REG_ADDR_W + 1;
  localparam int EX_MEM_W = REG_ADDR_W + 1 + REG_BUS_W + ALU_OP_BUS_W + 2 * REG_BUS_W;
  localparam int MEM_WB_W = REG_ADDR_W + 1 + REG_BUS_W;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter with synchronous clear
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - generic valid/ready pipeline stage with 2-entry skid buffer
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W        = 64,
  parameter logic [DATA_W-1:0]  BUBBLE        = NOP_PAYLOAD[DATA_W-1:0],
  parameter int                 ZERO_ON_EMPTY = 1,
  parameter int                 CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cycles,
  input  logic              bp_clr
);

  pipe_state_e       state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_xfer;
  logic              out_xfer;
  logic [DATA_W-1:0] main_on_empty;

  assign in_xfer       = in_valid && in_ready_q;
  assign out_xfer      = out_valid && out_ready;
  assign main_on_empty = (ZERO_ON_EMPTY != 0) ? BUBBLE : main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PS_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != PS_TWO);
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_xfer) begin
            state_d = PS_ONE;
            main_d  = in_data;
          end
        end
        PS_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = PS_TWO;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = PS_EMPTY;
            main_d  = main_on_empty;
          end
        end
        PS_TWO: begin
          // in_ready is low here, so the skid entry is the only candidate for main.
          if (out_xfer) begin
            state_d = PS_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = PS_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != PS_EMPTY);
    occupancy = state_q;
    in_ready  = in_ready_q;
    out_data  = main_q;
  end

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_bp_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bp_clr),
    .inc  (out_valid && !out_ready),
    .count(bp_cycles)
  );

endmodule
